// File: rtl/mux_scan_controller.sv
// mux_scan_controller: scans an 8x1 mux and returns its eight inputs as a byte.
//
// On a start request the controller walks the select {s2,s1,s0} through 0..7.
// Each select value is held for STEP_DIV cycles. On the last cycle of each
// step it samples the mux output y into a shadow byte. After select 7 it loads
// the assembled byte into data and pulses done for one cycle.
//
// Optional feature: define MUX_SCAN_PARITY_EN to add a parity output. It is
// loaded on the same edge as data and always equals ^data.
//
// Handshake: start is a level request. It is sampled only while idle, and a
// high level at an idle edge launches a scan. While busy is high, start is
// ignored. done is a single-cycle strobe with no back-pressure. data and
// parity stay stable until the next done or reset.
//
// state_dbg exposes the FSM encoding: 0 = IDLE, 1 = SCAN, 2 = DONE.

module mux_scan_controller #(
  parameter int STEP_DIV = 3,
  parameter int DIV_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic [1:0] state_dbg
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  // STEP_DIV of 0 is treated as 1, so the last divider count is then 0 too.
  localparam logic [DIV_W-1:0] LAST_DIV =
    (STEP_DIV <= 1) ? '0 : DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       idx;
  logic [DIV_W-1:0] divcnt;
  logic [6:0]       shadow;
  logic             step_end;
  logic             last_step;

  // A step ends when the current select value has been held STEP_DIV cycles.
  assign step_end  = (state == S_SCAN) && (divcnt == LAST_DIV);
  assign last_step = step_end && (idx == 3'd7);

  // State register; reset aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only matters in IDLE, and DONE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: step divider, select index, shadow capture and byte load.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= 3'd0;
      divcnt <= '0;
      shadow <= 7'd0;
      data   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx    <= 3'd0;
            divcnt <= '0;
          end
        end
        S_SCAN: begin
          if (step_end) begin
            divcnt <= '0;
            if (idx == 3'd7) begin
              // Bit 7 goes straight into data; the select returns to 0.
              data <= {y, shadow};
              idx  <= 3'd0;
            end else begin
              shadow[idx] <= y;
              idx         <= idx + 3'd1;
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        default: begin
          idx    <= 3'd0;
          divcnt <= '0;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // Parity is loaded with data, from the same bits, so it tracks ^data exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (last_step) begin
      parity <= ^{y, shadow};
    end
  end
`endif

  // Output decode. The select lines come straight from the idx register,
  // which is held at 0 outside of SCAN.
  always_comb begin
    s0        = idx[0];
    s1        = idx[1];
    s2        = idx[2];
    busy      = (state == S_SCAN);
    done      = (state == S_DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Bench for mux_scan_controller. Two instances run side by side, one with
// STEP_DIV=1 and one with STEP_DIV=3. Both share clk, rst, start and the
// mux input byte. A time-based reference model predicts select, busy, done
// and data every cycle, and directed scenarios add literal expectations.

module tb_mux_scan_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] mux_in;
  logic [1:0] y;
  logic [1:0] s0;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] busy;
  logic [1:0] done;
  logic [7:0] data_q [2];
  logic [1:0] st_dbg [2];
`ifdef MUX_SCAN_PARITY_EN
  logic [1:0] par;
`endif

  int total;
  int bad;
  int cyc;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- the scanned muxes ----------------
  assign y[0] = mux_in[{s2[0], s1[0], s0[0]}];
  assign y[1] = mux_in[{s2[1], s1[1], s0[1]}];

  mux_scan_controller #(.STEP_DIV(1), .DIV_W(8)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .y(y[0]),
    .s0(s0[0]), .s1(s1[0]), .s2(s2[0]),
    .busy(busy[0]), .done(done[0]), .data(data_q[0]),
    .state_dbg(st_dbg[0])
`ifdef MUX_SCAN_PARITY_EN
    , .parity(par[0])
`endif
  );

  mux_scan_controller #(.STEP_DIV(3), .DIV_W(8)) u_d3 (
    .clk(clk), .rst(rst), .start(start), .y(y[1]),
    .s0(s0[1]), .s1(s1[1]), .s2(s2[1]),
    .busy(busy[1]), .done(done[1]), .data(data_q[1]),
    .state_dbg(st_dbg[1])
`ifdef MUX_SCAN_PARITY_EN
    , .parity(par[1])
`endif
  );

  // ---------------- reference model ----------------
  // Each scan is tracked by the number of edges n since its start edge.
  // With step length D, select = n / D. Bit j is sampled at edge (j+1)*D from
  // mux_in[j]. Edge 8*D delivers the byte and opens the one-cycle done window.
  int         dstep [2];
  bit         m_valid;
  bit         m_act  [2];
  int         m_n    [2];
  logic [7:0] m_shadow [2];
  logic [7:0] m_data [2];
  logic [2:0] m_sel  [2];
  logic       m_busy [2];
  logic       m_done [2];

  initial begin
    dstep[0] = 1;
    dstep[1] = 3;
    m_valid  = 1'b0;
  end

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i]    = 1'b0;
        m_n[i]      = 0;
        m_data[i]   = 8'h00;
        m_shadow[i] = 8'h00;
        m_sel[i]    = 3'd0;
        m_busy[i]   = 1'b0;
        m_done[i]   = 1'b0;
      end else if (m_act[i]) begin
        m_n[i]++;
        if (m_n[i] % dstep[i] == 0) begin
          m_shadow[i][m_n[i] / dstep[i] - 1] = mux_in[m_n[i] / dstep[i] - 1];
        end
        if (m_n[i] == 8 * dstep[i]) begin
          m_act[i]  = 1'b0;
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
          m_sel[i]  = 3'd0;
          m_data[i] = m_shadow[i];
        end else begin
          m_sel[i] = 3'(m_n[i] / dstep[i]);
        end
      end else if (m_done[i]) begin
        m_done[i] = 1'b0;
      end else if (start) begin
        m_act[i]  = 1'b1;
        m_n[i]    = 0;
        m_busy[i] = 1'b1;
        m_sel[i]  = 3'd0;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int inst,
                       input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d actual=%h required=%h", name, inst, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        check("sel",  i, {5'd0, s2[i], s1[i], s0[i]}, {5'd0, m_sel[i]});
        check("busy", i, {7'd0, busy[i]}, {7'd0, m_busy[i]});
        check("done", i, {7'd0, done[i]}, {7'd0, m_done[i]});
        check("data", i, data_q[i], m_data[i]);
`ifdef MUX_SCAN_PARITY_EN
        check("parity", i, {7'd0, par[i]}, {7'd0, ^m_data[i]});
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Raises start for one edge; returns the cycle number of that edge.
  task automatic pulse_start(output int k);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
  endtask

  // Waits for a done pulse on one instance, bounded by limit cycles.
  task automatic wait_done(input int inst, input int limit, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      if (done[inst] === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout inst%0d actual=none required=pulse within %0d cycles", inst, limit);
    end
  endtask

  // One scan of value v on both instances, with literal data/latency checks.
  task automatic run_scan(input logic [7:0] v, input logic [7:0] e0, input logic [7:0] e1);
    int k;
    int t;
    mux_in = v;
    pulse_start(k);
    wait_done(0, 40, t);
    check("lit_lat", 0, 8'(t - k), 8'd8);
    check("lit_data", 0, data_q[0], e0);
    wait_done(1, 40, t);
    check("lit_lat", 1, 8'(t - k), 8'd24);
    check("lit_data", 1, data_q[1], e1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int k;
    int t;
    int t2;
    total  = 0;
    bad    = 0;
    cyc    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    mux_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a scan.
    mux_in = 8'hC3;
    pulse_start(k);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("lit_rst_data", i, data_q[i], 8'h00);
      check("lit_rst_busy", i, {7'd0, busy[i]}, 8'h00);
      check("lit_rst_sel",  i, {5'd0, s2[i], s1[i], s0[i]}, 8'h00);
    end
    repeat (2) @(negedge clk);

    // Plain scans.
    run_scan(8'hA5, 8'hA5, 8'hA5);
    run_scan(8'h3C, 8'h3C, 8'h3C);
`ifdef MUX_SCAN_PARITY_EN
    check("lit_parity", 1, {7'd0, par[1]}, 8'h00);
`endif

    // Input changes mid-scan, plus a start request while busy.
    // After the change, the D=1 scan has bits 0..4 from 8'h01 and 5..7 from 8'hFF.
    mux_in = 8'h01;
    pulse_start(k);
    repeat (5) @(negedge clk);
    mux_in = 8'hFF;
    pulse_start(t);
    wait_done(0, 40, t);
    check("lit_lat", 0, 8'(t - k), 8'd8);
    check("lit_data_chg", 0, data_q[0], 8'hE1);
    wait_done(1, 40, t);
    check("lit_lat", 1, 8'(t - k), 8'd24);
    check("lit_data_chg", 1, data_q[1], 8'hFF);
    repeat (4) @(negedge clk);

    // start held high: back-to-back scans, period 8*D+2.
    mux_in = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    wait_done(0, 40, t);
    wait_done(0, 40, t2);
    check("lit_period", 0, 8'(t2 - t), 8'd10);
    check("lit_data_rep", 0, data_q[0], 8'h5A);
    wait_done(1, 60, t);
    wait_done(1, 60, t2);
    check("lit_period", 1, 8'(t2 - t), 8'd26);
    check("lit_data_rep", 1, data_q[1], 8'h5A);
    start = 1'b0;
    repeat (30) @(negedge clk);

    // Reset while the STEP_DIV=3 instance is at select 4.
    mux_in = 8'h96;
    pulse_start(k);
    repeat (12) @(negedge clk);
    check("lit_sel_before_rst", 1, {5'd0, s2[1], s1[1], s0[1]}, 8'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("lit_rst_data", 1, data_q[1], 8'h00);
    check("lit_rst_done", 1, {7'd0, done[1]}, 8'h00);
    repeat (30) @(negedge clk);
    run_scan(8'h96, 8'h96, 8'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
